s713_misr_compactor: RTL and testbench

- Output-response compactor placed directly downstream of the s713 benchmark core.
- Folds the core's 23 primary outputs into a 23-bit multiple-input signature register (MISR), one valid sample per cycle, for a programmed number of test patterns.
- Discards a programmable number of warm-up samples while the core's 19 flip-flops settle from an unknown state.
- At the end, exposes the signature and a pass/fail flag against a golden signature; used by the fault-simulation and BIST flow.

---
 rtl/s713_misr_compactor.sv | 109 ++++++++++
 tb/tb_s713_misr_compactor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/s713_misr_compactor.sv
// MISR output-response compactor for the s713 benchmark core: warm-up discard, signature fold, golden compare.
// Optional X-masking of core outputs is enabled by defining MISR_XMASK_EN (adds the XMASK input port).
module s713_misr_compactor #(
    parameter int               WIDTH        = 23,
    parameter logic [WIDTH-1:0] POLY         = 23'h000021,
    parameter logic [WIDTH-1:0] SEED         = 23'h000000,
    parameter int               NUM_PATTERNS = 256,
    parameter int               WARMUP       = 4,
    parameter int               CNT_W        = 16
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
`ifdef MISR_XMASK_EN
    input  logic [WIDTH-1:0] XMASK,
`endif
    input  logic [WIDTH-1:0] GOLDEN,
    output logic [WIDTH-1:0] SIGNATURE,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARM,
        S_COMPACT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP > 0 ? WARMUP - 1 : 0);
    localparam logic [CNT_W-1:0] PAT_LAST  = CNT_W'(NUM_PATTERNS > 0 ? NUM_PATTERNS - 1 : 0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic [WIDTH-1:0] din_eff;
    logic [WIDTH-1:0] misr_next;

`ifdef MISR_XMASK_EN
    assign din_eff = DIN & ~XMASK;
`else
    assign din_eff = DIN;
`endif

    assign misr_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ din_eff;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    sig_d   = SEED;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    state_d = (WARMUP == 0) ? S_COMPACT : S_WARM;
                end
            end
            S_WARM: begin
                if (DIN_VALID) begin
                    if (cnt_q == WARM_LAST) begin
                        cnt_d   = '0;
                        state_d = S_COMPACT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_COMPACT: begin
                if (DIN_VALID) begin
                    sig_d = misr_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    // The compare must see the signature including this final sample.
                    if (cnt_q == PAT_LAST) begin
                        pass_d  = (misr_next == GOLDEN);
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign SIGNATURE = sig_q;
    assign BUSY      = (state_q == S_WARM) || (state_q == S_COMPACT);
    assign DONE      = (state_q == S_DONE);
    assign PASS      = pass_q;

endmodule

// File: tb/tb_s713_misr_compactor.sv
// Self-checking bench for s713_misr_compactor: three configurations, vector table, scoreboard runs.
// Exercises the XMASK port when MISR_XMASK_EN is defined.
module tb_s713_misr_compactor;

    localparam int W = 23;

    logic         ck = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic [W-1:0] gold = '0;
    logic [W-1:0] xmask = '0;

    logic         start_a = 1'b0, vld_a = 1'b0;
    logic         start_b = 1'b0, vld_b = 1'b0;
    logic         start_c = 1'b0, vld_c = 1'b0;
    logic [W-1:0] sig_a, sig_b, sig_c;
    logic         busy_a, done_a, pass_a;
    logic         busy_b, done_b, pass_b;
    logic         busy_c, done_c, pass_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] din;
        logic         vld;
        logic [W-1:0] exp_sig;
        logic         exp_busy;
        logic         exp_done;
        logic         exp_pass;
    } vec_t;

    vec_t         vecs[5];
    logic [W-1:0] exp_q[$];

    always #5 ck = ~ck;

    s713_misr_compactor #(.SEED(23'h000000), .WARMUP(0), .NUM_PATTERNS(4)) u_a (
        .CK(ck), .RST(rst), .START(start_a), .DIN(din), .DIN_VALID(vld_a),
`ifdef MISR_XMASK_EN
        .XMASK(xmask),
`endif
        .GOLDEN(gold), .SIGNATURE(sig_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a));

    s713_misr_compactor #(.SEED(23'h400000), .WARMUP(0), .NUM_PATTERNS(1)) u_b (
        .CK(ck), .RST(rst), .START(start_b), .DIN(din), .DIN_VALID(vld_b),
`ifdef MISR_XMASK_EN
        .XMASK(xmask),
`endif
        .GOLDEN(gold), .SIGNATURE(sig_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b));

    s713_misr_compactor #(.SEED(23'h000000), .WARMUP(4), .NUM_PATTERNS(2)) u_c (
        .CK(ck), .RST(rst), .START(start_c), .DIN(din), .DIN_VALID(vld_c),
`ifdef MISR_XMASK_EN
        .XMASK(xmask),
`endif
        .GOLDEN(gold), .SIGNATURE(sig_c), .BUSY(busy_c), .DONE(done_c), .PASS(pass_c));

    function automatic logic [W-1:0] misr_step(input logic [W-1:0] s, input logic [W-1:0] d);
        return {s[W-2:0], 1'b0} ^ (s[W-1] ? 23'h000021 : 23'h000000) ^ d;
    endfunction

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [W-1:0] model_sig;
        int           warm_left;
        int           left;
        int           cycles;

        // Reset values, checked while reset is still asserted.
        #12;
        check_output("rst_sig_a", 32'(sig_a), 32'h000000);
        check_output("rst_sig_b", 32'(sig_b), 32'h400000);
        check_output("rst_busy_a", 32'(busy_a), 32'd0);
        check_output("rst_done_a", 32'(done_a), 32'd0);
        check_output("rst_pass_a", 32'(pass_a), 32'd0);
        @(negedge ck);
        rst = 1'b0;
        tick();

        // Basic shift on u_a, one gap cycle inserted.
        vecs[0] = '{23'h000001, 1'b1, 23'h000001, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{23'h000000, 1'b1, 23'h000002, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{23'h7FFFFF, 1'b0, 23'h000002, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{23'h000000, 1'b1, 23'h000004, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{23'h000000, 1'b1, 23'h000008, 1'b0, 1'b1, 1'b1};
        gold = 23'h000008;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_output("shift_busy_start", 32'(busy_a), 32'd1);
        check_output("shift_sig_start", 32'(sig_a), 32'h0);
        for (int i = 0; i < 5; i++) begin
            din   = vecs[i].din;
            vld_a = vecs[i].vld;
            tick();
            check_output($sformatf("vec%0d_sig", i), 32'(sig_a), 32'(vecs[i].exp_sig));
            check_output($sformatf("vec%0d_busy", i), 32'(busy_a), 32'(vecs[i].exp_busy));
            check_output($sformatf("vec%0d_done", i), 32'(done_a), 32'(vecs[i].exp_done));
            check_output($sformatf("vec%0d_pass", i), 32'(pass_a), 32'(vecs[i].exp_pass));
        end
        vld_a = 1'b0;
        tick();
        check_output("shift_hold_sig", 32'(sig_a), 32'h000008);
        check_output("shift_hold_pass", 32'(pass_a), 32'd1);

        // Feedback on u_b: top bit wraps into the taps.
        gold  = 23'h000000;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        din   = 23'h000000;
        vld_b = 1'b1;
        tick();
        vld_b = 1'b0;
        check_output("fb_sig", 32'(sig_b), 32'h000021);
        check_output("fb_done", 32'(done_b), 32'd1);
        check_output("fb_pass", 32'(pass_b), 32'd0);

        // Warm-up with idle gaps on u_c.
        gold = 23'h000006;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din   = 23'h7FFFFF;
            vld_c = 1'b1;
            tick();
            check_output($sformatf("warm%0d_sig", i), 32'(sig_c), 32'h0);
            check_output($sformatf("warm%0d_busy", i), 32'(busy_c), 32'd1);
            vld_c = 1'b0;
            tick();
            check_output($sformatf("gap%0d_sig", i), 32'(sig_c), 32'h0);
        end
        din   = 23'h000003;
        vld_c = 1'b1;
        tick();
        check_output("warm_c1_sig", 32'(sig_c), 32'h000003);
        din = 23'h000000;
        tick();
        vld_c = 1'b0;
        check_output("warm_c2_sig", 32'(sig_c), 32'h000006);
        check_output("warm_done", 32'(done_c), 32'd1);
        check_output("warm_pass", 32'(pass_c), 32'd1);

        // Scoreboard runs on u_c, each restarted from DONE, random data and gaps.
        for (int run = 0; run < 4; run++) begin
            start_c = 1'b1;
            tick();
            start_c = 1'b0;
            check_output("sb_busy_start", 32'(busy_c), 32'd1);
            model_sig = 23'h000000;
            warm_left = 4;
            left      = 2;
            cycles    = 0;
            while (left > 0 && cycles < 100) begin
                din   = W'($urandom);
                vld_c = ($urandom_range(0, 3) != 0);
                if (vld_c) begin
                    if (warm_left > 0) begin
                        warm_left--;
                    end else begin
                        model_sig = misr_step(model_sig, din);
                        left--;
                        if (left == 0) gold = run[0] ? model_sig : (model_sig ^ 23'h000001);
                    end
                end
                exp_q.push_back(model_sig);
                tick();
                check_output("sb_sig", 32'(sig_c), 32'(exp_q.pop_front()));
                cycles++;
            end
            vld_c = 1'b0;
            if (left > 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_timeout actual=%0d required=0 samples left", left);
            end
            check_output("sb_done", 32'(done_c), 32'd1);
            check_output("sb_pass", 32'(pass_c), 32'(run[0]));
        end

        // Restart from DONE with PASS set: clears PASS, returns to WARM.
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        check_output("restart_sig", 32'(sig_c), 32'h0);
        check_output("restart_pass", 32'(pass_c), 32'd0);
        check_output("restart_busy", 32'(busy_c), 32'd1);
        check_output("restart_done", 32'(done_c), 32'd0);
        din   = 23'h123456;
        vld_c = 1'b1;
        tick();
        vld_c = 1'b0;
        check_output("restart_warm_hold", 32'(sig_c), 32'h0);

        // START while busy on u_a is ignored.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        din   = 23'h000005;
        vld_a = 1'b1;
        tick();
        check_output("busy_sig1", 32'(sig_a), 32'h000005);
        din     = 23'h000000;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        vld_a   = 1'b0;
        check_output("busy_start_sig", 32'(sig_a), 32'h00000A);
        check_output("busy_start_busy", 32'(busy_a), 32'd1);

        // Asynchronous reset mid-run, away from any clock edge.
        #3;
        rst = 1'b1;
        #1;
        check_output("arst_sig", 32'(sig_a), 32'h0);
        check_output("arst_busy", 32'(busy_a), 32'd0);
        check_output("arst_done", 32'(done_a), 32'd0);
        #2;
        rst = 1'b0;
        tick();
        check_output("arst_idle_busy", 32'(busy_a), 32'd0);

`ifdef MISR_XMASK_EN
        xmask   = 23'h000001;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        din   = 23'h000003;
        vld_a = 1'b1;
        tick();
        vld_a = 1'b0;
        check_output("xmask_sig", 32'(sig_a), 32'h000002);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
